// File: rtl/sra_pipe.sv
// Five-stage pipelined right shifter (logical or arithmetic), resolving one amount bit per stage.
// Defining SRA_PIPE_STICKY_EN builds the sticky chain (OR of all shifted-out bits); otherwise data_sticky is 0.
module sra_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [4:0]       ctrl_shiftamt,
  input  logic             ctrl_arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_result,
  output logic             data_sticky,
  output logic             busy
);
  // Stage s hands STAGES-1-s unused amount bits forward; they are packed back to back here.
  localparam int REM_BITS = STAGES * (STAGES - 1) / 2;

  logic [STAGES-1:0]   stg_v;
  logic [STAGES-1:0]   mv;
  logic [STAGES-1:0]   en;
  logic [STAGES-2:0]   stg_arith;
  logic [REM_BITS-1:0] stg_rem;
  logic [WIDTH-1:0]    stg_data [STAGES];
`ifdef SRA_PIPE_STICKY_EN
  logic [STAGES-1:0]   stg_sticky;
`endif

  // Handshake: valid and ready are independent; a transfer happens on any edge where both are high.
  // A stage moves when it is full and its successor is empty or moving; in_ready is purely combinational.
  always_comb begin
    mv = '0;
    mv[STAGES-1] = stg_v[STAGES-1] & out_ready;
    for (int s = STAGES - 2; s >= 0; s--) mv[s] = stg_v[s] & (~stg_v[s+1] | mv[s+1]);
  end

  assign en       = ~stg_v | mv;
  assign in_ready = en[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int SH   = 1 << s;
    localparam int AW   = STAGES - s;
    localparam int ROFF = s * (STAGES - 1) - s * (s - 1) / 2;

    logic [AW-1:0]    src_amt;
    logic [WIDTH-1:0] src_data;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             src_arith;
    logic             src_v;
    logic             v_q;
    logic             fill;

    if (s == 0) begin : g_src
      assign src_amt   = ctrl_shiftamt;
      assign src_data  = data_operandA;
      assign src_arith = ctrl_arith;
      assign src_v     = in_valid;
    end else begin : g_src
      localparam int POFF = (s - 1) * (STAGES - 1) - (s - 1) * (s - 2) / 2;
      assign src_amt   = stg_rem[POFF +: AW];
      assign src_data  = stg_data[s-1];
      assign src_arith = stg_arith[s-1];
      assign src_v     = stg_v[s-1];
    end

    // The msb never changes along the pipe, so it is always the original sign.
    assign fill   = src_arith & src_data[WIDTH-1];
    assign data_d = src_amt[0] ? {{SH{fill}}, src_data[WIDTH-1:SH]} : src_data;

    always_ff @(posedge clock) begin
      if (reset) begin
        v_q    <= 1'b0;
        data_q <= '0;
      end else if (en[s]) begin
        v_q    <= src_v;
        data_q <= data_d;
      end
    end

    assign stg_v[s]    = v_q;
    assign stg_data[s] = data_q;

    if (s < STAGES - 1) begin : g_fwd
      logic [AW-2:0] rem_q;
      logic          arith_q;

      always_ff @(posedge clock) begin
        if (reset) begin
          rem_q   <= '0;
          arith_q <= 1'b0;
        end else if (en[s]) begin
          rem_q   <= src_amt[AW-1:1];
          arith_q <= src_arith;
        end
      end

      assign stg_rem[ROFF +: AW-1] = rem_q;
      assign stg_arith[s]          = arith_q;
    end

`ifdef SRA_PIPE_STICKY_EN
    logic src_sticky;
    logic sticky_d;
    logic sticky_q;

    if (s == 0) begin : g_sin
      assign src_sticky = 1'b0;
    end else begin : g_sin
      assign src_sticky = stg_sticky[s-1];
    end

    assign sticky_d = src_sticky | (src_amt[0] & (|src_data[SH-1:0]));

    always_ff @(posedge clock) begin
      if (reset) sticky_q <= 1'b0;
      else if (en[s]) sticky_q <= sticky_d;
    end

    assign stg_sticky[s] = sticky_q;
`endif
  end

  assign out_valid   = stg_v[STAGES-1];
  assign data_result = stg_data[STAGES-1];
  assign busy        = |stg_v;

`ifdef SRA_PIPE_STICKY_EN
  assign data_sticky = stg_v[STAGES-1] & stg_sticky[STAGES-1];
`else
  assign data_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_sra_pipe.sv
// Directed bench for sra_pipe: hand-computed vectors plus an in-order scoreboard fed by a reference shift.
module tb_sra_pipe;
  localparam int W  = 32;
  localparam int EW = W + 1;
`ifdef SRA_PIPE_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_operandA;
  logic [4:0]   ctrl_shiftamt;
  logic         ctrl_arith;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] data_result;
  logic         data_sticky;
  logic         busy;

  logic [EW-1:0] exp_q[$];
  int            total;
  int            bad;
  logic          prev_stall;
  logic [W-1:0]  prev_data;

  sra_pipe dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data_operandA (data_operandA),
    .ctrl_shiftamt (ctrl_shiftamt),
    .ctrl_arith    (ctrl_arith),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .data_result   (data_result),
    .data_sticky   (data_sticky),
    .busy          (busy)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference and check helpers ----------------
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input logic [4:0] amt, input logic ar);
    logic [2*W-1:0] ext;
    ext = {(ar ? {W{a[W-1]}} : {W{1'b0}}), a};
    ext = ext >> amt;
    return ext[W-1:0];
  endfunction

  function automatic logic ref_sticky(input logic [W-1:0] a, input logic [4:0] amt);
    logic [W-1:0] mask;
    mask = (32'h1 << amt) - 32'h1;
    return STK & (|(a & mask));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [4:0] amt, input logic ar);
    in_valid      = 1'b1;
    data_operandA = a;
    ctrl_shiftamt = amt;
    ctrl_arith    = ar;
  endtask

  // Single op through an otherwise idle pipe: checks the 5th-cycle latency and the value.
  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [4:0] amt,
                         input logic ar, input logic [W-1:0] exp_data, input logic exp_stk);
    out_ready = 1'b1;
    drive(a, amt, ar);
    settle();
    chk({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    chk({tag, "_early_valid"}, out_valid, 0);
    step();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, data_result, exp_data);
    chk({tag, "_sticky"}, data_sticky, STK & exp_stk);
    step();
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) step();
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // ---------------- scoreboard (samples on the falling edge) ----------------
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (reset) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_valid", out_valid, 1);
        chk("stall_hold_data", data_result, prev_data);
      end
      if (exp_q.size() == 0) begin
        chk("idle_out_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
      end
      if (!out_valid) chk("sticky_unqualified", data_sticky, 0);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_data", data_result, e[W-1:0]);
        chk("sb_sticky", data_sticky, e[W]);
      end
      if (in_valid && in_ready)
        exp_q.push_back({ref_sticky(data_operandA, ctrl_shiftamt),
                         ref_shift(data_operandA, ctrl_shiftamt, ctrl_arith)});
      prev_stall = out_valid & ~out_ready;
      prev_data  = data_result;
    end
  end

  // ---------------- directed sequence ----------------
  logic [W-1:0] b2b_exp [8];
  logic [W-1:0] bp_a    [6];
  logic [4:0]   bp_amt  [6];
  logic         bp_ar   [6];
  logic [W-1:0] bp_exp  [6];

  initial begin
    int issued;
    total = 0;
    bad   = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    b2b_exp = '{32'h80000000, 32'hC0000000, 32'hE0000000, 32'hF0000000,
                32'hF8000000, 32'hFC000000, 32'hFE000000, 32'hFF000000};
    bp_a    = '{32'hF0000000, 32'hF0000000, 32'h00000100, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h80000001};
    bp_amt  = '{5'd4, 5'd4, 5'd8, 5'd1, 5'd1, 5'd1};
    bp_ar   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bp_exp  = '{32'h0F000000, 32'hFF000000, 32'h00000001, 32'h55555555, 32'hD5555555, 32'h40000000};

    // reset, with an op offered while reset is high (must be ignored)
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    data_operandA = '0;
    ctrl_shiftamt = '0;
    ctrl_arith = 1'b0;
    repeat (2) step();
    drive(32'hDEADBEEF, 5'd3, 1'b1);
    repeat (2) step();
    reset = 1'b0;
    in_valid = 1'b0;
    settle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data_result, 0);
    chk("rst_sticky", data_sticky, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (6) step();
    chk("rst_ignored_op", out_valid, 0);

    // sign fill, logical fill and the extremes
    run_one("arith4", 32'h80000000, 5'd4, 1'b1, 32'hF8000000, 1'b0);
    run_one("logic4", 32'h80000000, 5'd4, 1'b0, 32'h08000000, 1'b0);
    run_one("logic31", 32'hFFFFFFFF, 5'd31, 1'b0, 32'h00000001, 1'b1);
    run_one("amt0", 32'h12345678, 5'd0, 1'b1, 32'h12345678, 1'b0);
    run_one("arith31", 32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, 1'b0);
    run_one("arith16pos", 32'h7FFFFFFF, 5'd16, 1'b1, 32'h00007FFF, 1'b1);

    // back-to-back: one result per cycle, in_ready never drops
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) drive(32'h80000000, 5'(c), 1'b1);
      else in_valid = 1'b0;
      settle();
      if (c < 8) chk("b2b_in_ready", in_ready, 1);
      step();
      if (c >= 4) begin
        chk("b2b_valid", out_valid, 1);
        chk("b2b_data", data_result, b2b_exp[c-4]);
      end
    end
    drain("b2b");

    // backpressure: five fill the pipe, the sixth waits until out_ready rises
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(bp_a[k], bp_amt[k], bp_ar[k]);
      settle();
      chk("bp_in_ready_open", in_ready, 1);
      step();
    end
    drive(bp_a[5], bp_amt[5], bp_ar[5]);
    settle();
    chk("bp_full_in_ready", in_ready, 0);
    chk("bp_full_valid", out_valid, 1);
    chk("bp_full_head", data_result, bp_exp[0]);
    chk("bp_full_busy", busy, 1);
    step();
    chk("bp_still_full", in_ready, 0);
    chk("bp_still_head", data_result, bp_exp[0]);
    out_ready = 1'b1;
    settle();
    chk("bp_release_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    for (int j = 1; j < 6; j++) begin
      chk("bp_drain_valid", out_valid, 1);
      chk("bp_drain_data", data_result, bp_exp[j]);
      step();
    end
    drain("bp");

    // random in_valid / out_ready, results checked by the scoreboard
    issued = 0;
    for (int t = 0; t < 6000 && issued < 300; t++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) drive($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      else in_valid = 1'b0;
      settle();
      if (in_valid && in_ready) issued++;
      step();
    end
    in_valid = 1'b0;
    chk("rand_issued", issued, 300);
    drain("rand");

    // reset mid-flight discards three ops
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(32'h11110000 + k, 5'(k + 1), 1'b0);
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    for (int t = 0; t < 8; t++) begin
      step();
      chk("midrst_no_output", out_valid, 0);
    end
    run_one("post_rst", 32'hC0000000, 5'd2, 1'b1, 32'hF0000000, 1'b0);
    drain("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
